// File: rtl/data_select_pipe.sv
// rtl/data_select_pipe.sv - decoded switch-vector pipeline with memory-wait issue blocking
module data_select_pipe #(
    parameter int STAGES   = 3,
    parameter int MEM_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    input  logic [15:0]           op,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  op_ready,
    output logic [6*STAGES-1:0]   stage_sw,
    output logic [STAGES-1:0]     stage_valid,
    output logic [5:0]            out_sw,
    output logic                  out_valid
);

    // A load/store only blocks issue when the memory needs wait cycles at all.
    localparam bit         HAS_WAIT  = (MEM_WAIT > 0);
    // The counter holds "remaining blocked cycles minus one"; leaving WAIT happens on the zero edge.
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_cnt_next;

    logic [5:0]        r_sw [STAGES];
    logic [STAGES-1:0] r_valid;

    logic       w_accept;
    logic       w_is_mem;
    logic [5:0] w_dec_sw;

    // Switch settings for each instruction class; bit0 is switch 1.
    function automatic logic [5:0] f_decode(input logic [15:0] i_op);
        logic [5:0] v_sw;
        v_sw = 6'b000000;
        case (i_op[15:14])
            2'b11:   v_sw = (i_op[7:4] == 4'b1100) ? 6'b011000 : 6'b000000;
            2'b10:   v_sw = (i_op[13:11] <= 3'b010) ? 6'b000100 : 6'b000111;
            2'b00:   v_sw = 6'b010100;
            default: v_sw = 6'b100100;
        endcase
        return v_sw;
    endfunction

    assign w_dec_sw = f_decode(op);
    assign w_accept = op_valid & op_ready;
    assign w_is_mem = ~op[15];

    // FSM state register and wait counter; stall freezes both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Next-state logic: flush wins, stall holds, load/store accepts open the wait window.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        if (flush) begin
            w_state_next    = ST_RUN;
            w_wait_cnt_next = 4'd0;
        end else if (!stall) begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept && w_is_mem && HAS_WAIT) begin
                        w_state_next    = ST_WAIT;
                        w_wait_cnt_next = WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_next    = ST_RUN;
                    w_wait_cnt_next = 4'd0;
                end
            endcase
        end
    end

    // Output logic: issue is open only in RUN and when the pipe is free to move; closed during reset.
    always_comb begin
        op_ready = rst_n && (r_state == ST_RUN) && !stall && !flush;
    end

    // Switch-vector pipeline: stage 0 takes the decoded op or a bubble, later stages shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sw[i] <= 6'b000000;
            end
            r_valid <= '0;
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sw[i] <= 6'b000000;
            end
            r_valid <= '0;
        end else if (!stall) begin
            r_sw[0]    <= w_accept ? w_dec_sw : 6'b000000;
            r_valid[0] <= w_accept;
            for (int i = 1; i < STAGES; i++) begin
                r_sw[i]    <= r_sw[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Flatten stage registers onto the observation ports; the output is masked so bubbles read zero.
    always_comb begin
        stage_sw = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_sw[6*i +: 6] = r_sw[i];
        end
        stage_valid = r_valid;
        out_valid   = r_valid[STAGES-1];
        out_sw      = r_sw[STAGES-1] & {6{r_valid[STAGES-1]}};
    end

endmodule

// File: tb/tb_data_select_pipe.sv
// tb/tb_data_select_pipe.sv - randomized and directed bench for data_select_pipe
module tb_data_select_pipe;

    localparam int STAGES   = 3;
    localparam int MEM_WAIT = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                op_valid;
    logic [15:0]         op;
    logic                stall;
    logic                flush;
    logic                op_ready;
    logic [6*STAGES-1:0] stage_sw;
    logic [STAGES-1:0]   stage_valid;
    logic [5:0]          out_sw;
    logic                out_valid;

    data_select_pipe #(.STAGES(STAGES), .MEM_WAIT(MEM_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .stall(stall), .flush(flush),
        .op_ready(op_ready), .stage_sw(stage_sw), .stage_valid(stage_valid),
        .out_sw(out_sw), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: n counts pipeline-advancing edges; an op accepted on advance n
    // sits in stage i once the count reaches n+i. blocked counts issue-blocked edges left.
    int         n = 0;
    int         blocked = 0;
    logic [5:0] vmap [int];

    function automatic logic [5:0] ref_decode(input logic [15:0] w);
        int cls;
        cls = int'(w[15:14]);
        if (cls == 3) return (w[7:4] == 4'hC) ? 6'h18 : 6'h00;
        if (cls == 2) return (int'(w[13:11]) < 3) ? 6'h04 : 6'h07;
        if (cls == 0) return 6'h14;
        return 6'h24;
    endfunction

    function automatic logic ref_ready();
        return rst_n && (blocked == 0) && !stall && !flush;
    endfunction

    function automatic logic [6*STAGES-1:0] ref_stage_sw();
        logic [6*STAGES-1:0] v;
        v = '0;
        for (int i = 0; i < STAGES; i++)
            if (vmap.exists(n - i)) v[6*i +: 6] = vmap[n - i];
        return v;
    endfunction

    function automatic logic [STAGES-1:0] ref_stage_valid();
        logic [STAGES-1:0] v;
        v = '0;
        for (int i = 0; i < STAGES; i++) v[i] = vmap.exists(n - i);
        return v;
    endfunction

    task automatic model_reset();
        vmap.delete();
        blocked = 0;
        n = 0;
    endtask

    task automatic tick();
        logic rdy;
        rdy = ref_ready();
        @(posedge clk);
        if (flush) begin
            vmap.delete();
            blocked = 0;
            n++;
        end else if (!stall) begin
            n++;
            if (blocked > 0) blocked--;
            if (op_valid && rdy) begin
                vmap[n] = ref_decode(op);
                if (!op[15] && MEM_WAIT > 0) blocked = MEM_WAIT;
            end
        end
        #1;
    endtask

    task automatic idle();
        op_valid = 1'b0; op = 16'h0000; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (STAGES + MEM_WAIT + 1) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b1; op = 16'hC0C0; stall = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", op_ready); end
        checks++; if (stage_valid !== '0) begin errors++; $display("FAIL reset_stage_valid: got %b expected 0", stage_valid); end
        checks++; if (stage_sw !== '0) begin errors++; $display("FAIL reset_stage_sw: got %h expected 0", stage_sw); end
        checks++; if (out_valid !== 1'b0 || out_sw !== 6'h00) begin errors++; $display("FAIL reset_out: got %b/%b expected 0/000000", out_valid, out_sw); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b expected 1", op_ready); end
        tick();
        checks++; if (stage_valid[0] !== 1'b1 || stage_sw[5:0] !== 6'h18) begin errors++; $display("FAIL first_accept: got %b/%b expected 1/011000", stage_valid[0], stage_sw[5:0]); end
        drain();
    endtask

    task automatic test_single();
        op_valid = 1'b1; op = 16'hC0C0;
        tick();
        idle();
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (out_valid !== (e == 2) || out_sw !== ((e == 2) ? 6'h18 : 6'h00)) begin
                errors++; $display("FAIL single_latency_e%0d: got %b/%b expected %b/%b", e, out_valid, out_sw, (e == 2), ((e == 2) ? 6'h18 : 6'h00));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        op_valid = 1'b1; op = 16'h8000;
        tick();
        op = 16'hB800;
        tick();
        idle();
        tick();
        checks++; if (out_valid !== 1'b1 || out_sw !== 6'h04) begin errors++; $display("FAIL b2b_first: got %b/%b expected 1/000100", out_valid, out_sw); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_sw !== 6'h07) begin errors++; $display("FAIL b2b_second: got %b/%b expected 1/000111", out_valid, out_sw); end
        drain();
    endtask

    task automatic test_mem_wait();
        op_valid = 1'b1; op = 16'h0000;
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL mem_ready_before: got %b expected 1", op_ready); end
        tick();
        for (int c = 0; c < 5; c++) begin
            op_valid = (c < 2); op = 16'hC0C0;
            #1;
            if (c <= 2) begin
                checks++;
                if (op_ready !== (c == 2)) begin errors++; $display("FAIL mem_ready_c%0d: got %b expected %b", c, op_ready, (c == 2)); end
            end
            checks++;
            if (out_valid !== (c == 2) || out_sw !== ((c == 2) ? 6'h14 : 6'h00)) begin
                errors++; $display("FAIL mem_out_c%0d: got %b/%b expected %b/%b", c, out_valid, out_sw, (c == 2), ((c == 2) ? 6'h14 : 6'h00));
            end
            tick();
        end
        drain();
    endtask

    task automatic test_stall();
        op_valid = 1'b1; op = 16'hC0C0;
        tick();
        idle();
        tick();
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (stage_valid !== 3'b010 || stage_sw !== 18'h00600 || out_valid !== 1'b0) begin
                errors++; $display("FAIL stall_hold_s%0d: got %b/%h/%b expected 010/00600/0", s, stage_valid, stage_sw, out_valid);
            end
        end
        stall = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_sw !== 6'h18) begin errors++; $display("FAIL stall_late_out: got %b/%b expected 1/011000", out_valid, out_sw); end
        drain();
    endtask

    task automatic test_flush();
        op_valid = 1'b1; op = 16'h0000;
        tick();
        flush = 1'b1; stall = 1'b1; op_valid = 1'b1; op = 16'hC0C0;
        #1;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", op_ready); end
        tick();
        checks++; if (stage_valid !== '0 || stage_sw !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b/%h/%b expected 0/0/0", stage_valid, stage_sw, out_valid); end
        idle();
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL flush_run: got %b expected 1", op_ready); end
        drain();
    endtask

    task automatic test_async_reset();
        op_valid = 1'b1; op = 16'hC0C0;
        tick();
        op = 16'h4000;
        tick();
        idle();
        tick();
        checks++; if (out_valid !== 1'b1 || out_sw !== 6'h18) begin errors++; $display("FAIL areset_pre: got %b/%b expected 1/011000", out_valid, out_sw); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_sw !== 6'h00 || stage_valid !== '0) begin errors++; $display("FAIL areset_async: got %b/%b/%b expected 0/000000/000", out_valid, out_sw, stage_valid); end
        #2;
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL areset_wait_discard: got %b expected 1", op_ready); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            op_valid = ($urandom_range(0, 9) < 7);
            op       = 16'($urandom);
            stall    = ($urandom_range(0, 99) < 15);
            flush    = ($urandom_range(0, 99) < 5);
            #1;
            checks++;
            if (op_ready !== ref_ready()) begin errors++; $display("FAIL rnd_ready_c%0d: got %b expected %b", c, op_ready, ref_ready()); end
            checks++;
            if (stage_sw !== ref_stage_sw() || stage_valid !== ref_stage_valid()) begin
                errors++; $display("FAIL rnd_stages_c%0d: got %h/%b expected %h/%b", c, stage_sw, stage_valid, ref_stage_sw(), ref_stage_valid());
            end
            checks++;
            if (out_valid !== ref_stage_valid()[STAGES-1] || out_sw !== ref_stage_sw()[6*STAGES-1 -: 6]) begin
                errors++; $display("FAIL rnd_out_c%0d: got %b/%b expected %b/%b", c, out_valid, out_sw, ref_stage_valid()[STAGES-1], ref_stage_sw()[6*STAGES-1 -: 6]);
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mem_wait();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_select_pipe.md
DATA_SELECT_PIPE -- requirements
Module: data_select_pipe

Interface
REQ-001 Parameter STAGES, default 3, number of switch-vector pipeline stages (legal 1..8).
REQ-002 Parameter MEM_WAIT, default 2, issue-blocking cycles after a load/store accept (legal 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op_valid  input  1  op carries an instruction this cycle.
REQ-006 op  input  16  instruction word.
REQ-007 stall  input  1  freeze all pipeline state this cycle.
REQ-008 flush  input  1  discard all in-flight vectors this cycle.
REQ-009 op_ready  output  1  instruction accepted at this edge when op_valid=1.
REQ-010 stage_sw  output  6*STAGES  switch vector per stage; stage i at bits [6i+5:6i].
REQ-011 stage_valid  output  STAGES  valid flag per stage.
REQ-012 out_sw  output  6  last-stage switch vector; bit0=switch1 ... bit5=switch6.
REQ-013 out_valid  output  1  last-stage valid flag.

Function
REQ-014 Decode (bit5..bit0, i.e. sw6..sw1) SHALL be: op[15:14]=11 and op[7:4]=1100 -> 011000; 11 other -> 000000.
REQ-015 Decode: op[15:14]=10 and op[13:11] in {000,001,010} -> 000100; 10 other -> 000111.
REQ-016 Decode: op[15:14]=00 -> 010100; op[15:14]=01 -> 100100.
REQ-017 op_ready SHALL equal (state==RUN) and !stall and !flush, combinationally.
REQ-018 Accept = op_valid and op_ready; on accept, stage 0 SHALL load the decoded vector with valid=1.
REQ-019 When not stalled and no accept, stage 0 SHALL load a bubble (sw=000000, valid=0).
REQ-020 When not stalled, stage i (i>=1) SHALL load stage i-1 (vector and valid) each edge.
REQ-021 Bubbles SHALL always carry sw=000000; out_sw SHALL be 000000 whenever out_valid=0.
REQ-022 Latency: vector of op accepted at edge k SHALL appear on out_sw/out_valid after edge k+STAGES-1, plus one cycle per intervening stall cycle.
REQ-023 stall=1 (flush=0): all stage registers, FSM state and wait counter SHALL hold.
REQ-024 flush=1: all stages SHALL clear to bubble at the edge, FSM SHALL return to RUN, counter to 0; flush overrides stall and op_valid.
REQ-025 FSM states: RUN, WAIT.
REQ-026 RUN -> WAIT on accept of op[15] = 0 (load/store) when MEM_WAIT>0; counter loads MEM_WAIT-1.
REQ-027 WAIT: counter decrements per non-stalled edge; WAIT -> RUN on the edge where counter==0.
REQ-028 MEM_WAIT=0: WAIT never entered; load/store accepted back-to-back.
REQ-029 Branch and operation ops (op[15]=1) SHALL never enter WAIT.
REQ-030 STAGES=1: stage 0 is the output stage; latency per REQ-022 is zero extra edges.
REQ-031 op content while op_valid=0 or op_ready=0 SHALL have no effect on state.

Reset
REQ-032 rst_n=0 SHALL immediately, independent of clk, force all stage_sw=0, stage_valid=0, out_sw=000000, out_valid=0, FSM=RUN, counter=0.
REQ-033 op_ready SHALL be 0 while rst_n=0; first accept possible on the first edge with rst_n=1.
REQ-034 Reset asserted mid-WAIT or mid-stall SHALL discard all in-flight state.

Verification (STAGES=3, MEM_WAIT=2)
REQ-035 Accept op=16'hC0C0 at edge k, idle after -> out_sw=011000, out_valid=1 after edge k+2 only, then bubble.
REQ-036 Back-to-back op=16'h8000 then 16'hB800 -> out_sw 000100 then 000111 on consecutive cycles.
REQ-037 Accept op=16'h0000 -> op_ready=0 for exactly 2 cycles, then 1; out shows 010100 followed by 2 bubbles.
REQ-038 Vector in stage 1, stall=1 for 3 cycles -> stage_sw/stage_valid unchanged 3 cycles; output 3 cycles late.
REQ-039 flush=1 with stall=1 and op_valid=1 during WAIT -> all valid=0, op_ready=0 that cycle, state RUN next cycle.
REQ-040 rst_n low asynchronously mid-pipeline -> out_valid=0 and out_sw=000000 before next clk edge.
